tls3001_pixel_feeder: RTL and testbench

Upstream pixel source for the TLS3001 serializer. Holds a double-buffered image of `NUM_LEDS` RGB pixels with 12 bits per channel, written by a host port. On each serializer frame request, streams one 39-bit TLS3001 LED word per pixel over a valid/ready handshake. Buffers swap only at frame boundaries, so the serializer never sends a torn frame.

---
 rtl/tls3001_pkg.sv | 31 +++
 rtl/tls3001_pixel_bank.sv | 47 ++++
 rtl/tls3001_pixel_feeder.sv | 142 ++++++++++++++
 tb/tb_tls3001_pixel_feeder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tls3001_pkg.sv
// Shared definitions for the TLS3001 pixel feeder and serializer:
// field widths, channel selects, feeder FSM encoding and LED word packing.
package tls3001_pkg;

  localparam int CH_BITS   = 12;
  localparam int WORD_BITS = 39;
  localparam int LED_BITS  = 3 * CH_BITS;

  typedef enum logic [1:0] {
    CH_R    = 2'd0,
    CH_G    = 2'd1,
    CH_B    = 2'd2,
    CH_NONE = 2'd3
  } ch_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_PRESENT = 2'd2
  } feeder_state_e;

  // Each channel is preceded by a zero start bit; the word goes out MSB first.
  function automatic logic [WORD_BITS-1:0] tls3001_format_word(
    input logic [CH_BITS-1:0] r,
    input logic [CH_BITS-1:0] g,
    input logic [CH_BITS-1:0] b
  );
    return {1'b0, r, 1'b0, g, 1'b0, b};
  endfunction

endpackage

// File: rtl/tls3001_pixel_bank.sv
// Two pixel image banks with a per-channel write port and a registered read port.
// Bank contents are never reset; only the read register is.
module tls3001_pixel_bank
  import tls3001_pkg::*;
#(
  parameter int NUM_LEDS = 4,
  parameter int IDX_W    = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_wrEn,
  input  logic                i_wrBank,
  input  logic [IDX_W-1:0]    i_wrAddr,
  input  logic [1:0]          i_wrCh,
  input  logic [CH_BITS-1:0]  i_wrData,
  input  logic                i_rdEn,
  input  logic                i_rdBank,
  input  logic [IDX_W-1:0]    i_rdAddr,
  output logic [LED_BITS-1:0] o_rdData
);

  logic [LED_BITS-1:0] r_mem [2][NUM_LEDS];
  logic [LED_BITS-1:0] r_rdData;

  always_ff @(posedge i_clk) begin
    if (i_wrEn) begin
      case (i_wrCh)
        CH_R:    r_mem[i_wrBank][i_wrAddr][2*CH_BITS +: CH_BITS] <= i_wrData;
        CH_G:    r_mem[i_wrBank][i_wrAddr][CH_BITS +: CH_BITS]   <= i_wrData;
        CH_B:    r_mem[i_wrBank][i_wrAddr][0 +: CH_BITS]         <= i_wrData;
        default: ;
      endcase
    end
  end

  // Only loaded on request, so the caller can rely on it holding steady.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdData <= '0;
    end else if (i_rdEn) begin
      r_rdData <= r_mem[i_rdBank][i_rdAddr];
    end
  end

  assign o_rdData = r_rdData;

endmodule

// File: rtl/tls3001_pixel_feeder.sv
// Double-buffered pixel source for the TLS3001 serializer: host writes the back
// bank, frames stream from the front bank, and banks swap only at frame start.
module tls3001_pixel_feeder
  import tls3001_pkg::*;
#(
  parameter int NUM_LEDS = 4,
  parameter int ADDR_W   = 8
) (
  input  logic                 CLK_IN,
  input  logic                 RST_IN,
  input  logic                 WR_EN,
  input  logic [ADDR_W-1:0]    WR_ADDR,
  input  logic [1:0]           WR_CH,
  input  logic [CH_BITS-1:0]   WR_DATA,
  input  logic                 COMMIT,
  output logic                 COMMIT_PENDING,
  input  logic                 FRAME_REQ,
  output logic                 PIX_VALID,
  input  logic                 PIX_READY,
  output logic [WORD_BITS-1:0] PIX_DATA,
  output logic                 PIX_LAST,
  output logic                 BUSY
);

  localparam int                IDX_W     = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_LEDS - 1);
  localparam logic [ADDR_W:0]   LED_COUNT = (ADDR_W + 1)'(NUM_LEDS);

  feeder_state_e       r_state;
  feeder_state_e       w_nextState;
  logic                r_front;
  logic                r_commitPending;
  logic [ADDR_W-1:0]   r_idx;
  logic                r_pixValid;
  logic                r_pixLast;
  logic                w_wrAccept;
  logic                w_frameStart;
  logic                w_fetch;
  logic                w_accept;
  logic                w_isLast;
  logic [LED_BITS-1:0] w_rdData;

  assign w_isLast   = (r_idx == LAST_IDX);
  assign w_wrAccept = WR_EN && ({1'b0, WR_ADDR} < LED_COUNT) && (WR_CH != CH_NONE);

  // Host writes use the pre-swap back bank, so a write in the swap cycle
  // lands in the bank that becomes front for the frame being started.
  tls3001_pixel_bank #(
    .NUM_LEDS (NUM_LEDS),
    .IDX_W    (IDX_W)
  ) u_bank (
    .i_clk    (CLK_IN),
    .i_rst    (RST_IN),
    .i_wrEn   (w_wrAccept),
    .i_wrBank (~r_front),
    .i_wrAddr (WR_ADDR[IDX_W-1:0]),
    .i_wrCh   (WR_CH),
    .i_wrData (WR_DATA),
    .i_rdEn   (w_fetch),
    .i_rdBank (r_front),
    .i_rdAddr (r_idx[IDX_W-1:0]),
    .o_rdData (w_rdData)
  );

  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState  = r_state;
    w_frameStart = 1'b0;
    w_fetch      = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (FRAME_REQ) begin
          w_frameStart = 1'b1;
          w_nextState  = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_fetch     = 1'b1;
        w_nextState = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (r_pixValid && PIX_READY) begin
          w_accept    = 1'b1;
          w_nextState = w_isLast ? ST_IDLE : ST_FETCH;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // A commit seen together with the frame request swaps immediately instead of pending.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      r_front         <= 1'b0;
      r_commitPending <= 1'b0;
      r_idx           <= '0;
      r_pixValid      <= 1'b0;
      r_pixLast       <= 1'b0;
    end else begin
      if (w_frameStart) begin
        r_idx <= '0;
        if (r_commitPending || COMMIT) begin
          r_front         <= ~r_front;
          r_commitPending <= 1'b0;
        end
      end else if (COMMIT) begin
        r_commitPending <= 1'b1;
      end

      if (w_fetch) begin
        r_pixValid <= 1'b1;
        r_pixLast  <= w_isLast;
      end

      if (w_accept) begin
        r_pixValid <= 1'b0;
        r_pixLast  <= 1'b0;
        if (!w_isLast) begin
          r_idx <= r_idx + ADDR_W'(1);
        end
      end
    end
  end

  // The bank read register doubles as the output word register.
  assign PIX_DATA       = tls3001_format_word(w_rdData[2*CH_BITS +: CH_BITS],
                                              w_rdData[CH_BITS +: CH_BITS],
                                              w_rdData[0 +: CH_BITS]);
  assign PIX_VALID      = r_pixValid;
  assign PIX_LAST       = r_pixLast;
  assign COMMIT_PENDING = r_commitPending;
  assign BUSY           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_tls3001_pixel_feeder.sv
// Directed self-checking bench for tls3001_pixel_feeder: bank swap timing,
// backpressure, dropped writes, ignored requests and mid-frame reset.
module tb_tls3001_pixel_feeder;

  localparam int NUM_LEDS = 4;
  localparam int ADDR_W   = 8;

  logic        CLK_IN = 1'b0;
  logic        RST_IN;
  logic        WR_EN;
  logic [7:0]  WR_ADDR;
  logic [1:0]  WR_CH;
  logic [11:0] WR_DATA;
  logic        COMMIT;
  logic        COMMIT_PENDING;
  logic        FRAME_REQ;
  logic        PIX_VALID;
  logic        PIX_READY;
  logic [38:0] PIX_DATA;
  logic        PIX_LAST;
  logic        BUSY;

  int vecCount  = 0;
  int missCount = 0;

  tls3001_pixel_feeder #(
    .NUM_LEDS (NUM_LEDS),
    .ADDR_W   (ADDR_W)
  ) dut (
    .CLK_IN         (CLK_IN),
    .RST_IN         (RST_IN),
    .WR_EN          (WR_EN),
    .WR_ADDR        (WR_ADDR),
    .WR_CH          (WR_CH),
    .WR_DATA        (WR_DATA),
    .COMMIT         (COMMIT),
    .COMMIT_PENDING (COMMIT_PENDING),
    .FRAME_REQ      (FRAME_REQ),
    .PIX_VALID      (PIX_VALID),
    .PIX_READY      (PIX_READY),
    .PIX_DATA       (PIX_DATA),
    .PIX_LAST       (PIX_LAST),
    .BUSY           (BUSY)
  );

  always #5 CLK_IN = ~CLK_IN;

  // Arithmetic form of the LED word: R at bit 26, G at bit 13, B at bit 0.
  function automatic logic [38:0] expWord(input logic [11:0] r, input logic [11:0] g,
                                          input logic [11:0] b);
    return (39'(r) << 26) | (39'(g) << 13) | 39'(b);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    vecCount++;
    if (got !== want) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  // Advance one clock; samples happen 1ns after the edge and one-shot inputs drop.
  task automatic applyStimulus();
    @(posedge CLK_IN);
    #1;
    WR_EN     = 1'b0;
    COMMIT    = 1'b0;
    FRAME_REQ = 1'b0;
  endtask

  task automatic writeRaw(input logic [7:0] addr, input logic [1:0] ch, input logic [11:0] data);
    WR_EN   = 1'b1;
    WR_ADDR = addr;
    WR_CH   = ch;
    WR_DATA = data;
    applyStimulus();
  endtask

  task automatic writePixel(input logic [7:0] addr, input logic [11:0] r, input logic [11:0] g,
                            input logic [11:0] b);
    writeRaw(addr, 2'd0, r);
    writeRaw(addr, 2'd1, g);
    writeRaw(addr, 2'd2, b);
  endtask

  // Requests one frame with PIX_READY high and checks every word; optionally
  // stalls on one word and injects a commit, write and stray request mid-frame.
  task automatic runFrame(input string tag, input logic [38:0] e0, input logic [38:0] e1,
                          input logic [38:0] e2, input logic [38:0] e3,
                          input int stallIdx, input bit midAct);
    logic [38:0] expd [4];
    logic [38:0] hold;
    int n, cyc, firstCyc, unstable, stallAt;
    bit done;
    expd[0] = e0; expd[1] = e1; expd[2] = e2; expd[3] = e3;
    n = 0; cyc = 0; firstCyc = -1; done = 1'b0; stallAt = stallIdx;
    PIX_READY = 1'b1;
    FRAME_REQ = 1'b1;
    applyStimulus();
    checkOutput({tag, " busy after req"}, 64'(BUSY), 64'd1);
    checkOutput({tag, " pending after req"}, 64'(COMMIT_PENDING), 64'd0);
    while (!done && cyc < 200) begin
      if (PIX_VALID) begin
        if (firstCyc < 0) firstCyc = cyc;
        if (n == stallAt) begin
          PIX_READY = 1'b0;
          hold      = PIX_DATA;
          unstable  = 0;
          repeat (50) begin
            applyStimulus();
            if (PIX_VALID !== 1'b1 || PIX_DATA !== hold || BUSY !== 1'b1) unstable++;
          end
          checkOutput({tag, " stall stable"}, 64'(unstable), 64'd0);
          PIX_READY = 1'b1;
          stallAt   = -1;
        end
        if (n < NUM_LEDS) begin
          checkOutput($sformatf("%s word%0d data", tag, n), 64'(PIX_DATA), 64'(expd[n]));
          checkOutput($sformatf("%s word%0d last", tag, n), 64'(PIX_LAST), 64'(n == NUM_LEDS - 1));
        end
        n++;
        if (midAct && n == 3) begin
          COMMIT    = 1'b1;
          FRAME_REQ = 1'b1;
          WR_EN     = 1'b1;
          WR_ADDR   = 8'd1;
          WR_CH     = 2'd1;
          WR_DATA   = 12'hA5A;
        end
      end else if (!BUSY) begin
        done = 1'b1;
      end
      if (!done) begin
        applyStimulus();
        cyc++;
      end
    end
    checkOutput({tag, " frame ended in time"}, 64'(done), 64'd1);
    checkOutput({tag, " word count"}, 64'(n), 64'd4);
    checkOutput({tag, " first valid edges after req"}, 64'(firstCyc + 1), 64'd2);
    applyStimulus();
    checkOutput({tag, " idle after frame"}, 64'(BUSY), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n, cyc;
    bit found;
    RST_IN    = 1'b1;
    WR_EN     = 1'b0;
    WR_ADDR   = '0;
    WR_CH     = '0;
    WR_DATA   = '0;
    COMMIT    = 1'b0;
    FRAME_REQ = 1'b0;
    PIX_READY = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("reset valid", 64'(PIX_VALID), 64'd0);
    checkOutput("reset busy", 64'(BUSY), 64'd0);
    checkOutput("reset pending", 64'(COMMIT_PENDING), 64'd0);
    checkOutput("reset last", 64'(PIX_LAST), 64'd0);
    checkOutput("reset data", 64'(PIX_DATA), 64'd0);
    RST_IN = 1'b0;
    applyStimulus();

    // Image A into bank 1 (back while front is bank 0).
    writePixel(8'd0, 12'hFFF, 12'h000, 12'h0AA);
    writePixel(8'd1, 12'h123, 12'h456, 12'h789);
    writePixel(8'd2, 12'hABC, 12'hDEF, 12'h001);
    writePixel(8'd3, 12'h800, 12'h001, 12'h7FF);
    COMMIT = 1'b1;
    applyStimulus();
    checkOutput("commit sets pending", 64'(COMMIT_PENDING), 64'd1);
    COMMIT = 1'b1;
    applyStimulus();
    checkOutput("repeat commit pending", 64'(COMMIT_PENDING), 64'd1);

    runFrame("F1", 39'h3FFC0000AA, expWord(12'h123, 12'h456, 12'h789),
             expWord(12'hABC, 12'hDEF, 12'h001), expWord(12'h800, 12'h001, 12'h7FF), -1, 1'b0);

    // Image B into bank 0, then a frame with stall and mid-frame commit/write.
    writePixel(8'd0, 12'h111, 12'h222, 12'h333);
    writePixel(8'd1, 12'h444, 12'h555, 12'h666);
    writePixel(8'd2, 12'h777, 12'h888, 12'h999);
    writePixel(8'd3, 12'h000, 12'hFFF, 12'h000);
    runFrame("F2", 39'h3FFC0000AA, expWord(12'h123, 12'h456, 12'h789),
             expWord(12'hABC, 12'hDEF, 12'h001), expWord(12'h800, 12'h001, 12'h7FF), 1, 1'b1);
    checkOutput("F2 pending held", 64'(COMMIT_PENDING), 64'd1);
    applyStimulus();
    applyStimulus();
    checkOutput("idle pending held", 64'(COMMIT_PENDING), 64'd1);

    runFrame("F3", expWord(12'h111, 12'h222, 12'h333), expWord(12'h444, 12'hA5A, 12'h666),
             expWord(12'h777, 12'h888, 12'h999), expWord(12'h000, 12'hFFF, 12'h000), -1, 1'b0);

    // Dropped writes to bank 1, then commit + request + write in the same cycle.
    writeRaw(8'd1, 2'd3, 12'hEEE);
    writeRaw(8'd4, 2'd0, 12'h000);
    WR_EN   = 1'b1;
    WR_ADDR = 8'd2;
    WR_CH   = 2'd0;
    WR_DATA = 12'h555;
    COMMIT  = 1'b1;
    runFrame("F4", 39'h3FFC0000AA, expWord(12'h123, 12'h456, 12'h789),
             expWord(12'h555, 12'hDEF, 12'h001), expWord(12'h800, 12'h001, 12'h7FF), -1, 1'b0);

    // Reset while word 2 is presented with a commit pending.
    PIX_READY = 1'b1;
    FRAME_REQ = 1'b1;
    applyStimulus();
    COMMIT = 1'b1;
    applyStimulus();
    checkOutput("F5 mid commit pending", 64'(COMMIT_PENDING), 64'd1);
    n = 0; cyc = 0; found = 1'b0;
    while (!found && cyc < 50) begin
      if (PIX_VALID) begin
        if (n == 2) found = 1'b1;
        else n++;
      end
      if (!found) begin
        applyStimulus();
        cyc++;
      end
    end
    checkOutput("F5 reached word2", 64'(found), 64'd1);
    checkOutput("F5 word2 data", 64'(PIX_DATA), 64'(expWord(12'h555, 12'hDEF, 12'h001)));
    RST_IN    = 1'b1;
    PIX_READY = 1'b0;
    applyStimulus();
    checkOutput("midreset valid", 64'(PIX_VALID), 64'd0);
    checkOutput("midreset busy", 64'(BUSY), 64'd0);
    checkOutput("midreset pending", 64'(COMMIT_PENDING), 64'd0);
    checkOutput("midreset last", 64'(PIX_LAST), 64'd0);
    checkOutput("midreset data", 64'(PIX_DATA), 64'd0);
    RST_IN = 1'b0;
    applyStimulus();

    // Front is bank 0 again, so image B with the mid-frame edit comes out.
    runFrame("F6", expWord(12'h111, 12'h222, 12'h333), expWord(12'h444, 12'hA5A, 12'h666),
             expWord(12'h777, 12'h888, 12'h999), expWord(12'h000, 12'hFFF, 12'h000), -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
